// File: rtl/quant_stage.sv
// rtl/quant_stage.sv - per-lane reciprocal quantizer with one-row output register (optional table writes: QUANT_TBL_WR_EN)
module quant_stage #(
    parameter int IN_W  = 12,
    parameter int OUT_W = 12,
    parameter int LANES = 8,
    parameter int R_W   = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [LANES*IN_W-1:0]         in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [LANES*OUT_W-1:0]        out_data,
    output logic [$clog2(LANES)-1:0]      out_row,
    output logic                          out_last,
    input  logic                          tbl_we,
    input  logic [$clog2(LANES*LANES)-1:0] tbl_addr,
    input  logic [R_W-1:0]                tbl_data
);

    localparam int RW  = $clog2(LANES);
    localparam int P_W = IN_W + R_W + 1;
    localparam int Q_W = IN_W + 1;
    localparam int C_W = ((Q_W > OUT_W) ? Q_W : OUT_W) + 1;
    localparam logic [R_W-1:0] DEF_RECIP = R_W'(1) << (R_W - 4);
    localparam logic signed [C_W-1:0] SAT_MAX = (C_W'(1) <<< (OUT_W - 1)) - C_W'(1);
    localparam logic signed [C_W-1:0] SAT_MIN = -(C_W'(1) <<< (OUT_W - 1));
    localparam logic [P_W-1:0] HALF = P_W'(1) << (R_W - 1);

    logic [RW-1:0]          row_cnt;
    logic [R_W-1:0]         recip [LANES];
    logic [LANES*OUT_W-1:0] next_data;
    logic                   accept;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

`ifdef QUANT_TBL_WR_EN
    logic [R_W-1:0] tbl [LANES*LANES];

    // Reads below are combinational on the current contents, so a write in the
    // same cycle as a handshake only affects later rows.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LANES*LANES; i++) begin
                tbl[i] <= DEF_RECIP;
            end
        end else if (tbl_we) begin
            tbl[tbl_addr] <= tbl_data;
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_rd
        assign recip[l] = tbl[{row_cnt, RW'(l)}];
    end
`else
    logic unused_tbl;
    assign unused_tbl = ^{tbl_we, tbl_addr, tbl_data};

    for (genvar l = 0; l < LANES; l++) begin : g_rd
        assign recip[l] = DEF_RECIP;
    end
`endif

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic signed [IN_W-1:0]  coef;
        logic signed [R_W:0]     rcp;
        logic signed [P_W-1:0]   prod;
        logic signed [P_W-1:0]   rnd;
        logic signed [Q_W-1:0]   q;
        logic signed [C_W-1:0]   qx;
        logic        [OUT_W-1:0] sat;

        assign coef = in_data[(LANES-1-l)*IN_W +: IN_W];
        assign rcp  = {1'b0, recip[l]};
        assign prod = P_W'(coef) * P_W'(rcp);
        // Adding one half before the arithmetic shift rounds half toward +inf.
        assign rnd  = prod + HALF;
        assign q    = Q_W'(rnd >>> R_W);
        assign qx   = C_W'(q);

        always_comb begin
            sat = OUT_W'(qx);
            if (qx > SAT_MAX) begin
                sat = OUT_W'(SAT_MAX);
            end else if (qx < SAT_MIN) begin
                sat = OUT_W'(SAT_MIN);
            end
        end

        assign next_data[(LANES-1-l)*OUT_W +: OUT_W] = sat;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_row   <= '0;
            out_last  <= 1'b0;
            row_cnt   <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= next_data;
            out_row   <= row_cnt;
            out_last  <= (row_cnt == RW'(LANES - 1));
            row_cnt   <= (row_cnt == RW'(LANES - 1)) ? '0 : row_cnt + RW'(1);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_quant_stage.sv
// tb/tb_quant_stage.sv - self-checking bench for quant_stage against an arithmetic reference model
module tb_quant_stage;

    typedef struct packed {
        logic [95:0] data;
        logic [2:0]  row;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready, out_last;
    logic [95:0] in_data, out_data;
    logic [2:0]  out_row;
    logic        tbl_we;
    logic [5:0]  tbl_addr;
    logic [15:0] tbl_data;

    logic        in_valid8, in_ready8, out_valid8, out_ready8, out_last8;
    logic [95:0] in_data8;
    logic [63:0] out_data8;
    logic [2:0]  out_row8;

    int          checks = 0;
    int          failures = 0;
    int          n_in = 0;
    int          n_out = 0;
    int          mrow = 0;
    int          model_tbl [64];
    exp_t        exp_q [$];

    always #5 clk = ~clk;

    quant_stage dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_row(out_row), .out_last(out_last),
        .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_data(tbl_data)
    );

    quant_stage #(.OUT_W(8)) dut8 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8),
        .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8),
        .out_row(out_row8), .out_last(out_last8),
        .tbl_we(1'b0), .tbl_addr(6'd0), .tbl_data(16'd0)
    );

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic signed [11:0] lane(input logic [95:0] d, input int l);
        return d[(7-l)*12 +: 12];
    endfunction

    function automatic logic signed [7:0] lane8(input logic [63:0] d, input int l);
        return d[(7-l)*8 +: 8];
    endfunction

    // Quantized value = round-half-up(in * recip / 2^16), clamped to 12-bit signed.
    function automatic logic [95:0] model_row(input logic [95:0] din, input int row);
        logic [95:0] r;
        longint c, p, q;
        for (int l = 0; l < 8; l++) begin
            c = longint'($signed(din[(7-l)*12 +: 12]));
            p = c * longint'(model_tbl[row*8+l]) + 32768;
            q = p >>> 16;
            if (q > 2047) q = 2047;
            if (q < -2048) q = -2048;
            r[(7-l)*12 +: 12] = q[11:0];
        end
        return r;
    endfunction

    task automatic tick();
        exp_t e;
        #1;
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", 96'(out_row), 96'hx);
            end else begin
                e = exp_q.pop_front();
                chk("row_data", out_data, e.data);
                chk("row_index", 96'(out_row), 96'(e.row));
                chk("row_last", 96'(out_last), 96'(e.last));
            end
            n_out++;
        end
        if (!reset && in_valid && in_ready) begin
            e.data = model_row(in_data, mrow);
            e.row  = 3'(mrow);
            e.last = (mrow == 7);
            exp_q.push_back(e);
            mrow = (mrow + 1) % 8;
            n_in++;
        end
`ifdef QUANT_TBL_WR_EN
        if (!reset && tbl_we) model_tbl[tbl_addr] = int'(tbl_data);
`endif
        if (reset) begin
            exp_q.delete();
            mrow = 0;
            n_in = 0;
            n_out = 0;
            for (int i = 0; i < 64; i++) model_tbl[i] = 4096;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        tbl_we = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        logic [95:0] d, saved;
        int dir_in [4];
        int dir_out [4];
        dir_in  = '{100, -100, 8, -8};
        dir_out = '{6, -6, 1, 0};

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_data = '0;
        tbl_we = 1'b0; tbl_addr = '0; tbl_data = '0;
        in_valid8 = 1'b0; out_ready8 = 1'b1; in_data8 = '0;
        @(negedge clk);
        tick();
        tick();
        chk("reset_out_valid", 96'(out_valid), 96'(0));
        chk("reset_out_data", out_data, 96'(0));
        chk("reset_out_row", 96'(out_row), 96'(0));
        chk("reset_out_last", 96'(out_last), 96'(0));
        reset = 1'b0;
        #1;
        chk("in_ready_after_reset", 96'(in_ready), 96'(1));

        // Directed rounding points on lane 0 with the default table.
        for (int k = 0; k < 4; k++) begin
            d = {$urandom, $urandom, $urandom};
            d[95:84] = 12'(dir_in[k]);
            in_data = d; in_valid = 1'b1; out_ready = 1'b1;
            tick();
            in_valid = 1'b0;
            chk("round_lane0", 96'(lane(out_data, 0)), 96'(dir_out[k]));
            tick();
        end

        // Nine back-to-back rows: full block then wrap.
        do_reset();
        in_valid = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            in_data = {$urandom, $urandom, $urandom};
            tick();
            chk("b2b_valid", 96'(out_valid), 96'(1));
            chk("b2b_row", 96'(out_row), 96'(k % 8));
            chk("b2b_last", 96'(out_last), 96'(k == 7));
        end
        in_valid = 1'b0;
        tick();
        chk("valid_clears", 96'(out_valid), 96'(0));

        // Downstream stall holds the output row and blocks input.
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = {$urandom, $urandom, $urandom};
        tick();
        in_data = {$urandom, $urandom, $urandom};
        saved = out_data;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_in_ready", 96'(in_ready), 96'(0));
            chk("stall_valid", 96'(out_valid), 96'(1));
            chk("stall_hold", out_data, saved);
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("stall_no_loss", 96'(exp_q.size()), 96'(0));

        // Reset in the middle of a block.
        do_reset();
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_data = {$urandom, $urandom, $urandom};
            tick();
        end
        in_valid = 1'b0;
        reset = 1'b1;
        tick();
        chk("midreset_valid", 96'(out_valid), 96'(0));
        reset = 1'b0;
        #1;
        chk("midreset_in_ready", 96'(in_ready), 96'(1));
        in_valid = 1'b1;
        in_data = {$urandom, $urandom, $urandom};
        tick();
        in_valid = 1'b0;
        chk("midreset_row0", 96'(out_row), 96'(0));
        tick();

        // Table write to row 1 lane 1.
        do_reset();
        tbl_we = 1'b1; tbl_addr = 6'd9; tbl_data = 16'h8000;
        tick();
        tbl_we = 1'b0;
        in_data = {8{12'd10}}; in_valid = 1'b1;
        tick();
        chk("tbl_row0_lane1", 96'(lane(out_data, 1)), 96'(1));
        tick();
        in_valid = 1'b0;
`ifdef QUANT_TBL_WR_EN
        chk("tbl_row1_lane1", 96'(lane(out_data, 1)), 96'(5));
`else
        chk("tbl_row1_lane1", 96'(lane(out_data, 1)), 96'(1));
`endif
        chk("tbl_row1_lane0", 96'(lane(out_data, 0)), 96'(1));
        tick();

        // Narrow output saturation.
        in_data8 = {12'd2047, 12'h800, 72'd0}; in_valid8 = 1'b1;
        tick();
        in_valid8 = 1'b0;
        chk("sat8_valid", 96'(out_valid8), 96'(1));
        chk("sat8_pos", 96'(lane8(out_data8, 0)), 96'(127));
        chk("sat8_neg", 96'(lane8(out_data8, 1)), 96'(-128));
        chk("sat8_zero", 96'(lane8(out_data8, 2)), 96'(0));

        // Randomized traffic with back-pressure and table writes.
        do_reset();
        for (int k = 0; k < 400; k++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_data   = {$urandom, $urandom, $urandom};
            if ($urandom_range(0, 7) == 0) in_data[95:84] = 12'h800;
            tbl_we    = ($urandom_range(0, 5) == 0);
            tbl_addr  = 6'($urandom);
            tbl_data  = 16'($urandom);
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1; tbl_we = 1'b0;
        tick();
        tick();
        tick();
        chk("drain_empty", 96'(exp_q.size()), 96'(0));
        chk("drain_counts", 96'(n_out), 96'(n_in));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/quant_stage.md
QUANT_STAGE -- requirements
Module: quant_stage

Interface
REQ-001 SHALL have parameter IN_W, default 12, signed input coefficient width.
REQ-002 SHALL have parameter OUT_W, default 12, signed quantized output width.
REQ-003 SHALL have parameter LANES, default 8, coefficients per row and rows per block.
REQ-004 SHALL have parameter R_W, default 16, reciprocal table entry width; fraction bits = R_W.
REQ-005 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port in_valid  input  1  input row valid.
REQ-008 SHALL have port in_ready  output  1  stage can accept a row.
REQ-009 SHALL have port in_data  input  LANES*IN_W  row of signed coefficients; lane 0 in MSBs.
REQ-010 SHALL have port out_valid  output  1  output row valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts row.
REQ-012 SHALL have port out_data  output  LANES*OUT_W  quantized row; lane 0 in MSBs.
REQ-013 SHALL have port out_row  output  log2(LANES)  row index of out_data within the block.
REQ-014 SHALL have port out_last  output  1  high with last row (out_row = LANES-1).
REQ-015 SHALL have port tbl_we  input  1  table write strobe.
REQ-016 SHALL have port tbl_addr  input  log2(LANES*LANES)  table index = row*LANES + lane.
REQ-017 SHALL have port tbl_data  input  R_W  unsigned reciprocal (2^R_W / Q).

Function
REQ-018 SHALL hold a LANES*LANES table of unsigned R_W-bit reciprocals.
REQ-019 SHALL keep row counter row_cnt, incremented on each input handshake (in_valid && in_ready), wrapping LANES-1 -> 0.
REQ-020 SHALL compute per lane: p = in * zero_extended(table[row_cnt*LANES+lane]), signed, IN_W+R_W+1 bits.
REQ-021 SHALL round: q = (p + 2^(R_W-1)) >>> R_W (arithmetic shift, round half toward +inf).
REQ-022 SHALL saturate q to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-023 SHALL register result, row_cnt and last flag in one output stage; latency 1 cycle from handshake to out_valid.
REQ-024 SHALL drive in_ready = !out_valid || out_ready (full throughput, no bubble).
REQ-025 SHALL hold out_data, out_row, out_last stable while out_valid && !out_ready.
REQ-026 SHALL clear out_valid after output handshake when no new input accepted same cycle.
REQ-027 Table write and input handshake in same cycle: product SHALL use pre-write table value; write visible next cycle.
REQ-028 Reset mid-block SHALL discard output register contents and restart at row 0.

Reset
REQ-029 On reset: out_valid=0, row_cnt=0, out_data=0, out_row=0, out_last=0.
REQ-030 On reset: every table entry SHALL be 2^(R_W-4) (Q=16).
REQ-031 in_ready SHALL be 1 in the cycle after reset releases.

Configuration
REQ-032 Macro QUANT_TBL_WR_EN: defined -> tbl_we/tbl_addr/tbl_data write the table per REQ-027.
REQ-033 Undefined -> write ports SHALL be ignored; table constant at REQ-030 values.

Verification
REQ-034 Default table, lane 0 in=100 -> out=6; in=-100 -> out=-6; in=8 -> out=1 (0.5 rounds up); in=-8 -> out=0.
REQ-035 Eight back-to-back rows, out_ready=1 -> eight consecutive out_valid cycles, out_row 0..7, out_last only on row 7, 9th row out_row=0.
REQ-036 out_ready=0 for 3 cycles with out_valid=1 -> in_ready=0, out_data unchanged, no row lost or duplicated.
REQ-037 OUT_W=8, table=0xFFFF, in=2047 -> out=127; in=-2048 -> out=-128.
REQ-038 QUANT_TBL_WR_EN defined: write addr 9 = 0x8000, send rows 0,1 with in=10 -> row 1 lane 1 out=5, others 1 (10/16 rounds to 1); macro undefined -> row 1 lane 1 out=1.
REQ-039 Reset asserted after row 3 accepted -> out_valid=0 next cycle; next accepted row reports out_row=0.
